// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a registered select code 0..last_code with a programmable dwell per code,
// in single-sweep or continuous mode, for driving a 3-to-8 decoder.
module scan_sequencer #(
    parameter int CODE_W  = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CODE_W-1:0]  last_code,
    output logic [CODE_W-1:0]  code,
    output logic               code_valid,
    output logic               busy,
    output logic               wrap,
    output logic               done
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n, dwell_q, dwell_n;
    logic [CODE_W-1:0] code_n, last_q, last_n;
    logic single_q, single_n, wrap_n, done_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            code     <= '0;
            dwell_q  <= '0;
            last_q   <= '0;
            single_q <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            code     <= code_n;
            dwell_q  <= dwell_n;
            last_q   <= last_n;
            single_q <= single_n;
            wrap     <= wrap_n;
            done     <= done_n;
        end
    end
    // stop wins over start, advance and completion
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        code_n   = code;
        dwell_n  = dwell_q;
        last_n   = last_q;
        single_n = single_q;
        wrap_n   = 1'b0;
        done_n   = 1'b0;
        if (state == IDLE) begin
            if (start && !stop) begin
                state_n  = SCAN;
                cnt_n    = '0;
                code_n   = '0;
                dwell_n  = dwell;
                last_n   = last_code;
                single_n = single;
            end
        end else if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            code_n  = '0;
        end else if (cnt != dwell_q) begin
            cnt_n = cnt + DWELL_W'(1);
        end else begin
            cnt_n = '0;
            if (code != last_q) begin
                code_n = code + CODE_W'(1);
            end else begin
                code_n  = '0;
                state_n = single_q ? IDLE : SCAN;
                done_n  = single_q;
                wrap_n  = !single_q;
            end
        end
    end
    assign busy       = (state == SCAN);
    assign code_valid = (state == SCAN);
endmodule
